// File: rtl/axi4_wr_ctrl.sv
// AXI4 write-channel front end: accepts AW/W bursts, issues one single-word memory
// write per beat, and returns the B response. Burst-level errors suppress all writes.
module axi4_wr_ctrl #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_DEPTH      = 1024,
  parameter int MEM_ADDR_WIDTH = 10
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [ADDR_WIDTH-1:0]     AWADDR,
  input  logic [7:0]                AWLEN,
  input  logic [2:0]                AWSIZE,
  input  logic [1:0]                AWBURST,
  input  logic                      AWVALID,
  output logic                      AWREADY,
  input  logic [DATA_WIDTH-1:0]     WDATA,
  input  logic                      WLAST,
  input  logic                      WVALID,
  output logic                      WREADY,
  output logic [1:0]                BRESP,
  output logic                      BVALID,
  input  logic                      BREADY,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata
);

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  localparam logic [31:0] MEM_BYTES = 32'(MEM_DEPTH) * 32'd4;

  state_e                    state_q, state_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      mem_en_q, mem_en_d;
  logic                      mem_we_q, mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [7:0]                len_q, len_d;
  logic [7:0]                cnt_q, cnt_d;
  logic [1:0]                burst_q, burst_d;
  logic                      berr_q, berr_d;
  logic                      err_q, err_d;

  logic                  w_hs, last_beat, beat_oor, beat_err, aw_berr;
  logic [ADDR_WIDTH-1:0] addr_plus4, wrap_mask, next_addr;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d     = state_q;
    awready_d   = awready_q;
    wready_d    = wready_q;
    bvalid_d    = bvalid_q;
    bresp_d     = bresp_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    addr_d      = addr_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    berr_d      = berr_q;
    err_d       = err_q;

    w_hs       = WVALID && wready_q;
    last_beat  = (cnt_q == 8'd0);
    beat_oor   = !({{(32-ADDR_WIDTH){1'b0}}, addr_q} < MEM_BYTES);
    beat_err   = beat_oor || (WLAST != last_beat);
    aw_berr    = (AWSIZE != 3'b010) || (AWBURST == 2'b11) ||
                 ((AWBURST == 2'b10) && !(AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}));
    addr_plus4 = addr_q + ADDR_WIDTH'(4);
    // Wrap window is (len+1)*4 bytes; legal wrap lengths make that len*4+3 as a mask.
    wrap_mask  = ADDR_WIDTH'({len_q, 2'b11});

    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~wrap_mask) | (addr_plus4 & wrap_mask);
      default: next_addr = addr_plus4;
    endcase

    case (state_q)
      IDLE: begin
        awready_d = 1'b1;
        wready_d  = 1'b0;
        if (AWVALID && awready_q) begin
          addr_d    = AWADDR;
          len_d     = AWLEN;
          cnt_d     = AWLEN;
          burst_d   = AWBURST;
          berr_d    = aw_berr;
          err_d     = aw_berr;
          awready_d = 1'b0;
          wready_d  = 1'b1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (w_hs) begin
          if (!beat_oor && !berr_q) begin
            mem_en_d    = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = addr_q[MEM_ADDR_WIDTH+1:2];
            mem_wdata_d = WDATA;
          end
          err_d  = err_q || beat_err;
          addr_d = next_addr;
          cnt_d  = cnt_q - 8'd1;
          if (last_beat) begin
            wready_d = 1'b0;
            bvalid_d = 1'b1;
            bresp_d  = (err_q || beat_err) ? 2'b10 : 2'b00;
            state_d  = RESP;
          end
        end
      end
      RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          awready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (!ARESETn) begin
      state_q     <= IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      burst_q     <= '0;
      berr_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      berr_q      <= berr_d;
      err_q       <= err_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = wready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_axi4_wr_ctrl.sv
// Self-checking bench for axi4_wr_ctrl: directed burst table, reset corner cases,
// and random bursts checked beat-by-beat against an arithmetic address/response model.
module tb_axi4_wr_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID, AWREADY;
  logic [31:0] WDATA;
  logic        WLAST, WVALID, WREADY;
  logic [1:0]  BRESP;
  logic        BVALID, BREADY;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;

  axi4_wr_ctrl #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .MEM_DEPTH(1024), .MEM_ADDR_WIDTH(10)
  ) dut (
    .ACLK(clk), .ARESETn(rst_n),
    .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    int          bad_beat;      // beat whose WLAST is inverted, -1 for none
    int          bready_delay;
    logic [1:0]  exp_bresp;
    int          exp_writes;
  } vec_t;

  // Byte address of beat i from the AXI burst rules, in plain arithmetic.
  function automatic int beat_addr(input int start, input int len, input int burst, input int i);
    int size, base;
    case (burst)
      0: return start;
      2: begin
        size = (len + 1) * 4;
        base = start - (start % size);
        return base + ((start - base + 4 * i) % size);
      end
      default: return (start + 4 * i) & 'hFFFF;
    endcase
  endfunction

  function automatic bit burst_err(input int size, input int burst, input int len);
    return (size != 2) || (burst == 3) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one full burst starting at a negedge in IDLE; checks every beat against the model.
  task automatic do_burst(input vec_t v, input bit gaps,
                          output logic [1:0] got_bresp, output int got_writes,
                          output logic [1:0] model_bresp, output int model_writes);
    bit          berr, err, exp_strobe, wl;
    int          a;
    logic [31:0] data;
    berr = burst_err(int'(v.size), int'(v.burst), int'(v.len));
    err  = berr;
    got_writes   = 0;
    model_writes = 0;

    check("aw_ready_idle", AWREADY, 1);
    AWADDR = v.addr; AWLEN = v.len; AWSIZE = v.size; AWBURST = v.burst; AWVALID = 1'b1;
    idle_cycle();
    AWVALID = 1'b0;
    check("aw_ready_low", AWREADY, 0);
    check("w_ready_data", WREADY, 1);

    for (int i = 0; i <= int'(v.len); i++) begin
      a          = beat_addr(int'(v.addr), int'(v.len), int'(v.burst), i);
      exp_strobe = !berr && (a < 4096);
      if (!exp_strobe) err = 1'b1;
      wl = (i == int'(v.len)) ^ (i == v.bad_beat);
      if (i == v.bad_beat) err = 1'b1;
      data   = $urandom;
      WVALID = 1'b1; WDATA = data; WLAST = wl;
      idle_cycle();
      WVALID = 1'b0; WLAST = 1'b0;
      check("mem_en", mem_en, exp_strobe);
      check("mem_we", mem_we, exp_strobe);
      if (mem_en) got_writes++;
      if (exp_strobe) begin
        model_writes++;
        check("mem_addr", mem_addr, (a >> 2) & 1023);
        check("mem_wdata", mem_wdata, data);
      end
      if (i < int'(v.len)) begin
        check("w_ready_mid", WREADY, 1);
        check("b_valid_early", BVALID, 0);
        if (gaps && $urandom_range(0, 2) == 0) begin
          idle_cycle();
          check("mem_en_gap", mem_en, 0);
        end
      end else begin
        check("w_ready_end", WREADY, 0);
        check("b_valid", BVALID, 1);
      end
    end
    model_bresp = err ? 2'b10 : 2'b00;
    got_bresp   = BRESP;

    for (int d = 0; d < v.bready_delay; d++) begin
      idle_cycle();
      check("b_valid_hold", BVALID, 1);
      check("b_resp_hold", BRESP, got_bresp);
      check("aw_ready_resp", AWREADY, 0);
      check("mem_en_resp", mem_en, 0);
    end
    BREADY = 1'b1;
    idle_cycle();
    BREADY = 1'b0;
    check("b_valid_clear", BVALID, 0);
    check("aw_ready_after_b", AWREADY, 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[10];
    vec_t        v;
    logic [1:0]  gb, mb;
    int          gw, mw, r;

    //          addr     len    size    burst  badb dly  bresp  writes
    tbl[0] = '{16'h0010, 8'd3, 3'b010, 2'b01, -1, 5, 2'b00, 4};  // words 4..7
    tbl[1] = '{16'h0038, 8'd3, 3'b010, 2'b10, -1, 0, 2'b00, 4};  // words 14,15,12,13
    tbl[2] = '{16'h0FF8, 8'd3, 3'b010, 2'b01, -1, 1, 2'b10, 2};  // crosses end of memory
    tbl[3] = '{16'h0000, 8'd1, 3'b001, 2'b01, -1, 0, 2'b10, 0};  // illegal size
    tbl[4] = '{16'h0000, 8'd1, 3'b010, 2'b11, -1, 2, 2'b10, 0};  // reserved burst
    tbl[5] = '{16'h0100, 8'd3, 3'b010, 2'b01,  0, 0, 2'b10, 4};  // early WLAST
    tbl[6] = '{16'h0020, 8'd2, 3'b010, 2'b00, -1, 0, 2'b00, 3};  // FIXED
    tbl[7] = '{16'h0040, 8'd2, 3'b010, 2'b10, -1, 0, 2'b10, 0};  // WRAP with illegal length
    tbl[8] = '{16'h0040, 8'd1, 3'b010, 2'b01,  1, 0, 2'b10, 2};  // missing WLAST
    tbl[9] = '{16'h0FFE, 8'd1, 3'b010, 2'b10, -1, 0, 2'b00, 2};  // WRAP at top, unaligned

    rst_n = 1'b0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_awready", AWREADY, 0);
    check("rst_wready", WREADY, 0);
    check("rst_bvalid", BVALID, 0);
    check("rst_bresp", BRESP, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    idle_cycle();
    check("awready_after_rst", AWREADY, 1);

    // W data and BREADY before any AW handshake must be ignored.
    WVALID = 1'b1; WDATA = 32'hDEAD_BEEF; WLAST = 1'b1; BREADY = 1'b1;
    idle_cycle();
    check("early_w_wready", WREADY, 0);
    check("early_w_mem_en", mem_en, 0);
    check("early_bvalid", BVALID, 0);
    check("early_awready", AWREADY, 1);
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b0;

    for (int i = 0; i < 10; i++) begin
      do_burst(tbl[i], 1'b0, gb, gw, mb, mw);
      check($sformatf("tbl%0d_bresp", i), gb, tbl[i].exp_bresp);
      check($sformatf("tbl%0d_writes", i), gw, tbl[i].exp_writes);
    end

    // Reset in the middle of an 8-beat burst discards it.
    AWADDR = 16'h0000; AWLEN = 8'd7; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b1;
    idle_cycle();
    AWVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      WVALID = 1'b1; WDATA = 32'hA5A5_0000 + i; WLAST = 1'b0;
      idle_cycle();
      check("mid_rst_beat_we", mem_en, 1);
      check("mid_rst_beat_addr", mem_addr, i);
    end
    WVALID = 1'b0;
    rst_n  = 1'b0;
    idle_cycle();
    check("mid_rst_awready", AWREADY, 0);
    check("mid_rst_wready", WREADY, 0);
    check("mid_rst_bvalid", BVALID, 0);
    check("mid_rst_mem_en", mem_en, 0);
    check("mid_rst_mem_addr", mem_addr, 0);
    check("mid_rst_mem_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check("post_rst_bvalid", BVALID, 0);
      check("post_rst_mem_en", mem_en, 0);
    end
    v = '{16'h0200, 8'd0, 3'b010, 2'b01, -1, 0, 2'b00, 1};
    do_burst(v, 1'b0, gb, gw, mb, mw);
    check("post_rst_single_bresp", gb, 2'b00);
    check("post_rst_single_writes", gw, 1);

    // Random bursts against the model.
    for (int n = 0; n < 40; n++) begin
      v.addr = 16'($urandom_range(0, 'h1100));
      r = $urandom_range(0, 5);
      v.len  = (r == 0) ? 8'd0 : (r == 1) ? 8'd1 : (r == 2) ? 8'd3 :
               (r == 3) ? 8'd7 : (r == 4) ? 8'd15 : 8'($urandom_range(0, 15));
      r = $urandom_range(0, 9);
      v.burst = (r < 2) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      v.size  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
      v.bad_beat     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, int'(v.len))) : -1;
      v.bready_delay = $urandom_range(0, 3);
      v.exp_bresp    = 2'b00;
      v.exp_writes   = 0;
      do_burst(v, 1'b1, gb, gw, mb, mw);
      check("rnd_bresp", gb, mb);
      check("rnd_writes", gw, mw);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_wr_ctrl.md
Name: axi4_wr_ctrl

Overview:
AXI4 write-channel front end of the memory slave. Accepts AW/W bursts and issues one single-word write per beat on the memory interface (mem_en, mem_we, mem_addr, mem_wdata). Returns the B response.
- This block is the initiator on the memory interface; the memory array is the responder.
- All memory-interface outputs obey the memory-interface rules: mem_we implies mem_en, and mem_addr < MEM_DEPTH whenever mem_en is high.

Parameters:
ADDR_WIDTH, 16, AXI byte-address width
DATA_WIDTH, 32, AXI and memory data width (word = 4 bytes)
MEM_DEPTH, 1024, memory depth in words
MEM_ADDR_WIDTH, 10, memory word-address width (log2 MEM_DEPTH)

Ports:
ACLK  in  1  clock, all logic on the rising edge
ARESETn  in  1  reset, synchronous, active-low
AWADDR  in  ADDR_WIDTH  burst start byte address
AWLEN  in  8  beats minus 1
AWSIZE  in  3  beat size; only 3'b010 (4 bytes) is legal
AWBURST  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
AWVALID  in  1  address valid
AWREADY  out  1  address ready
WDATA  in  DATA_WIDTH  write data
WLAST  in  1  last beat marker
WVALID  in  1  data valid
WREADY  out  1  data ready
BRESP  out  2  00 OKAY, 10 SLVERR
BVALID  out  1  response valid
BREADY  in  1  response ready
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  MEM_ADDR_WIDTH  memory word address
mem_wdata  out  DATA_WIDTH  memory write data

Behaviour:
- Reset (ARESETn=0 at a rising edge):
  - State goes to IDLE.
  - AWREADY, WREADY, BVALID, mem_en and mem_we are 0; BRESP, mem_addr and mem_wdata are 0.
  - An in-flight burst is discarded: no B response and no memory write is produced for it.
  - AWREADY rises on the first clock with ARESETn=1.
- FSM states: IDLE, DATA, RESP. Outputs are registered.
- IDLE:
  - AWREADY=1, WREADY=0.
  - On AWVALID&&AWREADY, capture AWADDR, AWLEN, AWSIZE and AWBURST; load beat counter = AWLEN; clear err; go to DATA.
  - AWREADY=0 from the next cycle.
- Burst-level error: AWSIZE!=3'b010, AWBURST=2'b11, or WRAP with AWLEN not in {1,3,7,15}.
  - err is set.
  - All beats of the burst are still accepted, but none is written to memory.
- DATA:
  - WREADY=1.
  - Each W handshake at cycle N produces a write strobe at cycle N+1 only if the beat's byte address is < MEM_DEPTH*4 and there is no burst-level error. The strobe is mem_en=1, mem_we=1, mem_addr=byte_addr[MEM_ADDR_WIDTH+1:2], mem_wdata=WDATA, for exactly one cycle.
  - Otherwise mem_en and mem_we stay 0 for that beat and err is set.
  - Unaligned start address: the low two bits are ignored for the memory address.
- Address update after each beat:
  - FIXED: unchanged.
  - INCR: +4; no 4KB-boundary check beyond the range check.
  - WRAP: +4 within a window of (AWLEN+1)*4 bytes aligned to that size; wraps to the window base.
- WLAST checking:
  - WLAST=1 on a non-final beat, or WLAST=0 on the final beat, sets err.
  - The burst always ends after exactly AWLEN+1 beats.
- Final beat handshake at cycle M:
  - WREADY=0 and state RESP at M+1.
  - BVALID=1 at M+1, with BRESP=10 if err else 00.
- RESP:
  - BVALID and BRESP held stable until BREADY is sampled high.
  - Go to IDLE the next cycle; AWREADY=1 then.
- Throughput:
  - One beat per cycle while WVALID is held.
  - Minimum burst turnaround is AW handshake, then beats, then B handshake, then 1 idle cycle with AWREADY=1.
- Invariants:
  - mem_we is never 1 with mem_en=0.
  - mem_en is never 1 in IDLE or RESP, except on the strobe cycle for the final beat (M+1).
  - mem_en is never 1 when the address is out of range.
- Simultaneous events:
  - W data presented before the AW handshake is not accepted (WREADY=0 in IDLE).
  - BREADY high before BVALID has no effect.

Test Plan:
- Reset, then AWADDR=0x0010, AWLEN=3, INCR, data A0..A3 with WLAST on beat 4 -> mem writes at word addresses 4,5,6,7 with A0..A3, one per cycle each a cycle after its handshake; BVALID with BRESP=00.
- WRAP: AWADDR=0x0038, AWLEN=3 -> word addresses 14,15,12,13; BRESP=00.
- INCR: AWADDR=0x0FF8, AWLEN=3 -> words 1022 and 1023 written; beats 3–4 produce no mem_en; BRESP=10; mem_addr never >= 1024.
- AWSIZE=3'b001 or AWBURST=2'b11 with AWLEN=1 -> 2 beats accepted, zero mem_en pulses, BRESP=10; WLAST asserted on beat 1 of a 4-beat burst -> 4 writes still performed, BRESP=10.
- BREADY held low 5 cycles -> BVALID and BRESP stable for 5 cycles, AWREADY=0 throughout, IDLE one cycle after BREADY=1.
- ARESETn=0 after beat 2 of an 8-beat burst -> next cycle all outputs 0 and no BVALID for that burst; a new single-beat burst after reset completes with BRESP=00.
